// File: rtl/cmos_capture_window.sv
// cmos_capture_window: camera capture front end with settling-frame skip, byte packing,
// per-frame crop window, power-of-two decimation and continuous/single-shot capture.
// Ports:
//   cam_pclk, rst                  pixel clock and synchronous active-high reset
//   cam_vsync, cam_href, cam_data  raw camera bus
//   cap_en, cap_single, cap_start  capture control (continuous level, single-shot mode, trigger pulse)
//   win_x, win_y, win_w, win_h     crop window, latched once per frame
//   pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof  cropped pixel stream
//   cfg_ready, busy, cap_done, frame_cnt, line_len                 status
module cmos_capture_window #(
   parameter int DW         = 8,
   parameter int BPP        = 2,
   parameter int CW         = 11,
   parameter int WAIT_FRAME = 10,
   parameter int DEC_LOG2   = 0
) (
   input  logic               cam_pclk,
   input  logic               rst,
   input  logic               cam_vsync,
   input  logic               cam_href,
   input  logic [DW-1:0]      cam_data,
   input  logic               cap_en,
   input  logic               cap_single,
   input  logic               cap_start,
   input  logic [CW-1:0]      win_x,
   input  logic [CW-1:0]      win_y,
   input  logic [CW-1:0]      win_w,
   input  logic [CW-1:0]      win_h,
   output logic               pix_valid,
   output logic [DW*BPP-1:0]  pix_data,
   output logic [CW-1:0]      pix_x,
   output logic [CW-1:0]      pix_y,
   output logic               pix_sof,
   output logic               pix_eol,
   output logic               pix_eof,
   output logic               cfg_ready,
   output logic               busy,
   output logic               cap_done,
   output logic [15:0]        frame_cnt,
   output logic [CW-1:0]      line_len
);
   localparam int PW = DW * BPP;
   localparam logic [CW:0] STEP = (CW+1)'(1 << DEC_LOG2);
   localparam logic [CW:0] MASK = (CW+1)'((1 << DEC_LOG2) - 1);
   typedef enum logic [1:0] {WAIT, IDLE, ARM, CAP} state_t;
   state_t state;
   logic vs_d0, vs_d1, hr_d0, hr_d1;
   logic [1:0] phase;
   logic [PW-1:0] shift, pix_n;
   logic [CW-1:0] x, y, x_last, shx, shy, shw, shh, wx, wy, ww, wh;
   logic [15:0] wcnt;
   logic pos_vsync, href_fall, done, latch, in_cap, acc;
   logic [CW:0] xe, ye, dx, dy, xend, yend;
   always_comb begin
      pos_vsync = vs_d0 & ~vs_d1;
      href_fall = ~hr_d0 & hr_d1;
      done      = cam_href && phase == 2'(BPP - 1);
      pix_n     = PW'({shift, cam_data});
      // the window is re-latched whenever a captured frame begins, so a pixel that
      // completes on that same cycle is judged against the new window and y = 0
      latch     = pos_vsync && (state == ARM || (state == CAP && !cap_single && cap_en));
      in_cap    = pos_vsync ? latch : state == CAP;
      wx        = latch ? win_x : shx;
      wy        = latch ? win_y : shy;
      ww        = latch ? win_w : shw;
      wh        = latch ? win_h : shh;
      xe        = {1'b0, x};
      ye        = pos_vsync ? '0 : {1'b0, y};
      xend      = {1'b0, wx} + {1'b0, ww};
      yend      = {1'b0, wy} + {1'b0, wh};
      dx        = xe - {1'b0, wx};
      dy        = ye - {1'b0, wy};
      acc       = done && in_cap && xe >= {1'b0, wx} && xe < xend && ye >= {1'b0, wy} &&
                  ye < yend && (dx & MASK) == '0 && (dy & MASK) == '0;
      busy      = state == ARM || state == CAP;
   end
   always_ff @(posedge cam_pclk) begin
      if (rst) begin
         state <= WAIT;
         {vs_d0, vs_d1, hr_d0, hr_d1} <= '0;
         phase <= '0;
         shift <= '0;
         {x, y, x_last, shx, shy, shw, shh} <= '0;
         wcnt <= '0;
         {pix_valid, pix_sof, pix_eol, pix_eof, cfg_ready, cap_done} <= '0;
         pix_data <= '0;
         pix_x <= '0;
         pix_y <= '0;
         frame_cnt <= '0;
         line_len <= '0;
      end else begin
         vs_d0 <= cam_vsync;
         vs_d1 <= vs_d0;
         hr_d0 <= cam_href;
         hr_d1 <= hr_d0;
         if (cam_href) begin
            shift <= pix_n;
            phase <= done ? 2'd0 : phase + 2'd1;
            if (done) x <= x + CW'(1);
         end else begin
            shift <= '0;
            phase <= '0;
            x <= '0;
         end
         // x is already cleared by the time the delayed href fall is seen, so keep its final value
         if (!cam_href && hr_d0) x_last <= x;
         if (href_fall) line_len <= x_last;
         if (pos_vsync) y <= '0;
         else if (href_fall) y <= y + CW'(1);
         if (latch) {shx, shy, shw, shh} <= {win_x, win_y, win_w, win_h};
         cap_done <= 1'b0;
         case (state)
            WAIT:
               if (WAIT_FRAME == 0 || (pos_vsync && wcnt + 16'd1 == 16'(WAIT_FRAME))) begin
                  state <= IDLE;
                  cfg_ready <= 1'b1;
               end else if (pos_vsync) wcnt <= wcnt + 16'd1;
            IDLE: if (cap_single ? cap_start : cap_en) state <= ARM;
            ARM: if (pos_vsync) state <= CAP;
            CAP:
               if (pos_vsync) begin
                  frame_cnt <= frame_cnt + 16'd1;
                  cap_done <= 1'b1;
                  if (!latch) state <= IDLE;
               end
         endcase
         pix_valid <= acc;
         if (acc) begin
            pix_data <= pix_n;
            pix_x <= CW'(dx >> DEC_LOG2);
            pix_y <= CW'(dy >> DEC_LOG2);
            pix_sof <= dx == '0 && dy == '0;
            pix_eol <= xe + STEP >= xend;
            pix_eof <= xe + STEP >= xend && ye + STEP >= yend;
         end
      end
   end
endmodule
